// File: rtl/vector_pkg.sv
// Shared types and constants for the four-lane vector functional unit.
package vector_pkg;

    localparam int LANES = 4;
    localparam int WIDTH = 32;

    typedef logic [WIDTH-1:0] word_t;
    typedef word_t vec_t [0:LANES-1];

    typedef enum logic [2:0] {
        VADD = 3'b000,
        VSUB = 3'b001,
        VMUL = 3'b010,
        VAND = 3'b011,
        VOR  = 3'b100,
        VXOR = 3'b101,
        VSLL = 3'b110,
        VSRL = 3'b111
    } vfu_op_e;

endpackage

// File: rtl/vector_fu_lane.sv
// One combinational 32-bit lane of the vector functional unit.
module vector_fu_lane
    import vector_pkg::*;
(
    input  word_t   a,
    input  word_t   b,
    input  vfu_op_e op,
    output word_t   r
);

    word_t r_s;

    // Lane operation select; only b[4:0] is used as the shift amount.
    always_comb begin
        r_s = 32'h0000_0000;
        case (op)
            VADD:    r_s = a + b;
            VSUB:    r_s = a - b;
            VMUL:    r_s = a * b;
            VAND:    r_s = a & b;
            VOR:     r_s = a | b;
            VXOR:    r_s = a ^ b;
            VSLL:    r_s = a << b[4:0];
            VSRL:    r_s = a >> b[4:0];
            default: r_s = 32'h0000_0000;
        endcase
    end

    assign r = r_s;

endmodule

// File: rtl/vector_fu.sv
// Four-lane SIMD functional unit with a single registered result stage.
module vector_fu
    import vector_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  vec_t       A,
    input  vec_t       B,
    input  logic [2:0] operation,
    input  logic       valid,
    output vec_t       result,
    output logic       result_valid
);

    vec_t    lane_res_s;
    vec_t    result_r;
    logic    result_valid_r;
    vfu_op_e op_s;

    assign op_s = vfu_op_e'(operation);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_fu_lane u_lane (
            .a  (A[i]),
            .b  (B[i]),
            .op (op_s),
            .r  (lane_res_s[i])
        );
    end

    // Result register: loads on valid, otherwise holds; valid flag tracks input valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                result_r[i] <= 32'h0000_0000;
            end
            result_valid_r <= 1'b0;
        end else begin
            if (valid) begin
                result_r <= lane_res_s;
            end else begin
                result_r <= result_r;
            end
            result_valid_r <= valid;
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_vector_fu.sv
// Directed self-checking bench for vector_fu using immediate assertions.
module tb_vector_fu;
    import vector_pkg::*;

    logic       clk;
    logic       rst;
    vec_t       A;
    vec_t       B;
    logic [2:0] operation;
    logic       valid;
    vec_t       result;
    logic       result_valid;

    int checks;
    int errors;

    vector_fu dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .operation    (operation),
        .valid        (valid),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input vec_t exp);
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (result[i] === exp[i]) else begin
                errors++;
                $error("FAIL %s lane %0d observed %h expected %h", tag, i, result[i], exp[i]);
            end
        end
    endtask

    task automatic check_valid(input string tag, input logic exp);
        checks++;
        assert (result_valid === exp) else begin
            errors++;
            $error("FAIL %s result_valid observed %b expected %b", tag, result_valid, exp);
        end
    endtask

    // Drive on the falling edge, then sample just after the next rising edge.
    task automatic step(input vec_t a_v, input vec_t b_v, input logic [2:0] op, input logic v);
        @(negedge clk);
        A = a_v;
        B = b_v;
        operation = op;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    vec_t base_a, base_b, logic_a, logic_b, zero_v;

    initial begin
        checks = 0;
        errors = 0;
        zero_v  = '{32'h0, 32'h0, 32'h0, 32'h0};
        base_a  = '{32'h5, 32'h8, 32'h12, 32'h20};
        base_b  = '{32'h2, 32'h4, 32'h6, 32'h10};
        logic_a = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        logic_b = '{32'hFF00FF00, 32'd4, 32'd31, 32'd36};
        A = zero_v;
        B = zero_v;
        operation = 3'b000;
        valid = 1'b0;
        rst = 1'b1;
        #12;
        check_vec("reset", zero_v);
        check_valid("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(base_a, base_b, 3'b000, 1'b1);
        check_vec("add_base", '{32'h7, 32'hC, 32'h18, 32'h30});
        check_valid("add_base", 1'b1);
        step(base_a, base_b, 3'b001, 1'b1);
        check_vec("sub_base", '{32'h3, 32'h4, 32'hC, 32'h10});
        check_valid("sub_base", 1'b1);
        step(zero_v, zero_v, 3'b110, 1'b0);
        check_vec("hold_after_sub", '{32'h3, 32'h4, 32'hC, 32'h10});
        check_valid("hold_after_sub", 1'b0);
        step(base_a, base_b, 3'b010, 1'b1);
        check_vec("mul_base", '{32'hA, 32'h20, 32'h6C, 32'h200});

        step('{32'h0, 32'h0, 32'h1, 32'h80000000}, '{32'h1, 32'hFFFFFFFF, 32'h2, 32'h1}, 3'b001, 1'b1);
        check_vec("sub_wrap", '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF});
        step('{32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h0}, '{32'h1, 32'h80000000, 32'h1, 32'h0}, 3'b000, 1'b1);
        check_vec("add_wrap", '{32'h0, 32'h0, 32'h12345679, 32'h0});
        step('{32'h10000, 32'hFFFFFFFF, 32'h3, 32'h80000000}, '{32'h10000, 32'hFFFFFFFF, 32'h55555555, 32'h2}, 3'b010, 1'b1);
        check_vec("mul_trunc", '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h0});

        step(logic_a, logic_b, 3'b011, 1'b1);
        check_vec("and", '{32'hF000F000, 32'h0, 32'h10, 32'h20});
        step(logic_a, logic_b, 3'b100, 1'b1);
        check_vec("or", '{32'hFFF0FFF0, 32'hF0F0F0F4, 32'hF0F0F0FF, 32'hF0F0F0F4});
        step(logic_a, logic_b, 3'b101, 1'b1);
        check_vec("xor", '{32'h0FF00FF0, 32'hF0F0F0F4, 32'hF0F0F0EF, 32'hF0F0F0D4});
        step(logic_a, logic_b, 3'b110, 1'b1);
        check_vec("sll", '{32'hF0F0F0F0, 32'h0F0F0F00, 32'h0, 32'h0F0F0F00});
        step(logic_a, logic_b, 3'b111, 1'b1);
        check_vec("srl", '{32'hF0F0F0F0, 32'h0F0F0F0F, 32'h1, 32'h0F0F0F0F});
        check_valid("srl", 1'b1);

        // Asynchronous reset mid-cycle with a result in flight.
        @(negedge clk);
        A = base_a;
        B = base_b;
        operation = 3'b000;
        valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_vec("async_reset", zero_v);
        check_valid("async_reset", 1'b0);
        @(posedge clk);
        #1;
        check_vec("reset_held", zero_v);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check_valid("post_reset_idle", 1'b0);
        check_vec("post_reset_idle", zero_v);
        step(base_a, base_b, 3'b000, 1'b1);
        check_vec("post_reset_add", '{32'h7, 32'hC, 32'h18, 32'h30});
        check_valid("post_reset_add", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
